// File: rtl/puf_key_builder_if.sv
// PUF-side bus of puf_key_builder.
// The controller (master) drives enable, reset pulse and challenge.
// The ring-oscillator PUF (slave) returns the response and ready.
interface puf_key_builder_if;
  logic       puf_en;
  logic       puf_rst;
  logic [7:0] puf_chall;
  logic [7:0] puf_response;
  logic       puf_ready;

  modport master (output puf_en, puf_rst, puf_chall, input puf_response, puf_ready);
  modport slave  (input puf_en, puf_rst, puf_chall, output puf_response, puf_ready);
endinterface

// File: rtl/puf_key_builder.sv
// puf_key_builder: walks the ring-oscillator PUF through an LFSR challenge
// sequence, majority-votes REPEAT evaluations per challenge and packs the
// voted bytes into key (byte i = challenge i).
// Optional build macro STABILITY_FLAG_EN adds the unstable_mask output, which
// flags key bits whose votes were not unanimous.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// PRST  | one-cycle PUF reset pulse for the next evaluation
// WAIT  | waiting for puf_ready, bounded by TIMEOUT cycles
// DONE  | key complete and valid, waiting for start
// ERR   | PUF timed out, partial key kept, waiting for start
module puf_key_builder #(
  parameter int         NUM_CHALL  = 4,
  parameter int         REPEAT     = 3,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] CHALL_SEED = 8'hD4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   key_valid,
  output logic                   err,
  output logic [8*NUM_CHALL-1:0] key,
`ifdef STABILITY_FLAG_EN
  output logic [8*NUM_CHALL-1:0] unstable_mask,
`endif
  puf_key_builder_if.master      puf
);

  localparam int VW = $clog2(REPEAT + 1);
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int IW = (NUM_CHALL > 1) ? $clog2(NUM_CHALL) : 1;
  // A zero seed would lock the LFSR at zero.
  localparam logic [7:0] SEED0     = (CHALL_SEED == 8'h00) ? 8'h01 : CHALL_SEED;
  localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRST, S_WAIT, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [7:0]    chall;
  logic [RW-1:0] rep;
  logic [IW-1:0] idx;
  logic [7:0]    wait_left;
  logic [VW-1:0] vote [8];
  logic [VW-1:0] vote_sum [8];
  logic [7:0]    voted_byte;
  logic          done_q;
  logic          start_run, accept, byte_end, first_wait;

  // wait_left is loaded in PRST, so the first WAIT cycle still holds the load
  // value; ready is ignored there because it may be left over from the
  // previous evaluation.
  assign first_wait = (wait_left == WAIT_LOAD);

  // Per-bit tally including the response currently presented, and its majority
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      vote_sum[b]   = vote[b] + VW'(puf.puf_response[b]);
      voted_byte[b] = (vote_sum[b] > VW'(REPEAT / 2));
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    accept    = 1'b0;
    byte_end  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_PRST;
          start_run = 1'b1;
        end
      end
      S_PRST: state_d = S_WAIT;
      S_WAIT: begin
        if (puf.puf_ready && !first_wait) begin
          accept = 1'b1;
          if (rep != RW'(REPEAT - 1)) begin
            state_d = S_PRST;
          end else begin
            byte_end = 1'b1;
            state_d  = (idx == IW'(NUM_CHALL - 1)) ? S_DONE : S_PRST;
          end
        end else if (wait_left == 8'd0) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Challenge LFSR, repeat/index counters, timeout down-counter, votes and key
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chall     <= SEED0;
      rep       <= '0;
      idx       <= '0;
      wait_left <= '0;
      key       <= '0;
      done_q    <= 1'b0;
      for (int b = 0; b < 8; b++) vote[b] <= '0;
    end else begin
      done_q <= (state_q == S_WAIT) && (state_d == S_DONE);
      if (start_run) begin
        chall     <= SEED0;
        rep       <= '0;
        idx       <= '0;
        wait_left <= '0;
        key       <= '0;
        for (int b = 0; b < 8; b++) vote[b] <= '0;
      end else if (state_q == S_PRST) begin
        wait_left <= WAIT_LOAD;
      end else if (state_q == S_WAIT) begin
        if (byte_end) begin
          for (int i = 0; i < NUM_CHALL; i++)
            if (idx == IW'(i)) key[8*i +: 8] <= voted_byte;
          for (int b = 0; b < 8; b++) vote[b] <= '0;
          rep   <= '0;
          chall <= {chall[6:0], chall[7] ^ chall[5] ^ chall[4] ^ chall[3]};
          if (idx != IW'(NUM_CHALL - 1)) idx <= idx + IW'(1);
        end else if (accept) begin
          vote <= vote_sum;
          rep  <= rep + RW'(1);
        end else if (wait_left != 8'd0) begin
          wait_left <= wait_left - 8'd1;
        end
      end
    end
  end

`ifdef STABILITY_FLAG_EN
  logic [7:0] split_byte;

  // A bit is split when its final tally is neither all-zero nor all-one
  always_comb begin
    for (int b = 0; b < 8; b++)
      split_byte[b] = (vote_sum[b] != '0) && (vote_sum[b] != VW'(REPEAT));
  end

  // Stability flags, written alongside each key byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unstable_mask <= '0;
    end else if (start_run) begin
      unstable_mask <= '0;
    end else if (byte_end) begin
      for (int i = 0; i < NUM_CHALL; i++)
        if (idx == IW'(i)) unstable_mask[8*i +: 8] <= split_byte;
    end
  end
`endif

  assign busy          = (state_q == S_PRST) || (state_q == S_WAIT);
  assign done          = done_q;
  assign key_valid     = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign puf.puf_en    = busy;
  assign puf.puf_rst   = (state_q == S_PRST);
  assign puf.puf_chall = chall;

endmodule
